// File: rtl/fifo_word_packer.sv
// Byte FIFO read-side consumer: pops bytes, packs them LSB-first into words and
// emits full words, or partial words on idle timeout or flush, over valid/ready.
module fifo_word_packer #(
  parameter int PACK_BYTES = 4,
  parameter int TIMEOUT    = 16,
  parameter int BCNT_W     = $clog2(PACK_BYTES + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fifo_empty,
  input  logic [7:0]              fifo_data,
  output logic                    fifo_rd,
  input  logic                    flush_req,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [PACK_BYTES*8-1:0] m_data,
  output logic [BCNT_W-1:0]       m_bytes,
  output logic                    busy
);

  localparam int TMR_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic [BCNT_W-1:0] CNT_FULL = BCNT_W'(PACK_BYTES);
  localparam logic [BCNT_W-1:0] CNT_ZERO = {BCNT_W{1'b0}};

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [BCNT_W-1:0]       cnt_r;
  logic [BCNT_W-1:0]       cnt_nxt_s;
  logic [TMR_W-1:0]        timer_r;
  logic [PACK_BYTES*8-1:0] pack_r;
  logic                    pop_s;
  logic                    idle_s;
  logic                    tmo_s;
  logic                    seal_s;
  logic                    hshk_s;

  // Per-cycle qualifiers: pop, idle tick, timeout hit, word sealed, handshake.
  always_comb begin
    pop_s     = (state_r == ST_FILL) && !fifo_empty;
    cnt_nxt_s = cnt_r + {{(BCNT_W-1){1'b0}}, pop_s};
    idle_s    = (state_r == ST_FILL) && (cnt_r != CNT_ZERO) && fifo_empty && !flush_req;
    tmo_s     = (TIMEOUT != 0) && idle_s && (timer_r == TMR_LAST);
    seal_s    = (state_r == ST_FILL) &&
                ((cnt_nxt_s == CNT_FULL) || (flush_req && (cnt_nxt_s != CNT_ZERO)) || tmo_s);
    hshk_s    = (state_r == ST_SEND) && m_ready;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_FILL;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_FILL: begin
        if (seal_s) state_nxt_s = ST_SEND;
        else        state_nxt_s = ST_FILL;
      end
      ST_SEND: begin
        if (hshk_s) state_nxt_s = ST_FILL;
        else        state_nxt_s = ST_SEND;
      end
      default: state_nxt_s = ST_FILL;
    endcase
  end

  // Byte count, idle timer and pack register; cleared once the word is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r   <= CNT_ZERO;
      timer_r <= {TMR_W{1'b0}};
      pack_r  <= {(PACK_BYTES*8){1'b0}};
    end else if (hshk_s) begin
      cnt_r   <= CNT_ZERO;
      timer_r <= {TMR_W{1'b0}};
      pack_r  <= {(PACK_BYTES*8){1'b0}};
    end else if (state_r == ST_FILL) begin
      cnt_r <= cnt_nxt_s;
      if (pop_s) begin
        timer_r <= {TMR_W{1'b0}};
      end else if (idle_s) begin
        timer_r <= timer_r + {{(TMR_W-1){1'b0}}, 1'b1};
      end
      for (int i = 0; i < PACK_BYTES; i++) begin
        if (pop_s && (cnt_r == BCNT_W'(i))) pack_r[i*8 +: 8] <= fifo_data;
      end
    end
  end

  // Output decode; everything except the pop strobe comes straight from registers.
  always_comb begin
    fifo_rd = pop_s && !rst;
    busy    = (cnt_r != CNT_ZERO) || (state_r == ST_SEND);
    if (state_r == ST_SEND) begin
      m_valid = 1'b1;
      m_data  = pack_r;
      m_bytes = cnt_r;
    end else begin
      m_valid = 1'b0;
      m_data  = {(PACK_BYTES*8){1'b0}};
      m_bytes = CNT_ZERO;
    end
  end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: queue-based FIFO, byte-list reference model and
// a scoreboard monitor that checks every accepted word.
module tb_fifo_word_packer;
  localparam int PB  = 4;
  localparam int TMO = 16;
  localparam int BW  = $clog2(PB + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, fifo_empty, fifo_rd, flush_req, m_valid, m_ready, busy;
  logic [7:0]    fifo_data;
  logic [PB*8-1:0] m_data;
  logic [BW-1:0] m_bytes;
  // second instance with the timeout disabled
  logic          z_empty, z_rd, z_flush, z_valid, z_busy;
  logic [PB*8-1:0] z_data;
  logic [BW-1:0] z_bytes;

  fifo_word_packer #(.PACK_BYTES(PB), .TIMEOUT(TMO)) u_dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd(fifo_rd),
    .flush_req(flush_req), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_bytes(m_bytes), .busy(busy));

  fifo_word_packer #(.PACK_BYTES(PB), .TIMEOUT(0)) u_dut_notmo (
    .clk(clk), .rst(rst), .fifo_empty(z_empty), .fifo_data(8'hAA), .fifo_rd(z_rd),
    .flush_req(z_flush), .m_valid(z_valid), .m_ready(1'b1), .m_data(z_data),
    .m_bytes(z_bytes), .busy(z_busy));

  logic [7:0]    fq[$];        // FIFO contents, head at index 0
  logic [7:0]    acc[$];       // bytes popped toward the current word
  logic [63:0]   sb_d[$];
  int            sb_b[$];
  bit            mdl_sending;
  int            idle;
  int            n_cmp = 0, n_bad = 0;
  int            z_seen = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic seal();
    logic [63:0] w = 64'h0;
    for (int i = 0; i < acc.size(); i++) w[i*8 +: 8] = acc[i];
    sb_d.push_back(w);
    sb_b.push_back(acc.size());
    acc.delete();
    idle = 0;
    mdl_sending = 1'b1;
  endtask

  // One clock cycle: present FIFO head, check strobes, advance the model, pop on the edge.
  task automatic cyc();
    bit exp_pop, pend;
    fifo_empty = (fq.size() == 0);
    fifo_data  = fifo_empty ? 8'h00 : fq[0];
    #1;
    exp_pop = !rst && !mdl_sending && !fifo_empty;
    chk("fifo_rd", fifo_rd, exp_pop);
    chk("m_valid", m_valid, mdl_sending);
    chk("busy", busy, mdl_sending || (acc.size() > 0));
    pend = fifo_rd;
    if (rst) begin
      if (mdl_sending) begin
        void'(sb_d.pop_back());
        void'(sb_b.pop_back());
      end
      acc.delete();
      idle = 0;
      mdl_sending = 1'b0;
    end else if (mdl_sending) begin
      if (m_ready) mdl_sending = 1'b0;
    end else begin
      if (exp_pop) begin
        acc.push_back(fifo_data);
        idle = 0;
      end else if (acc.size() > 0 && !flush_req) begin
        idle++;
      end
      if (acc.size() == PB || (flush_req && acc.size() > 0) || (TMO != 0 && idle == TMO)) seal();
    end
    @(posedge clk);
    if (pend && fq.size() > 0) void'(fq.pop_front());
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic push4(input logic [31:0] w);
    for (int i = 0; i < 4; i++) fq.push_back(w[i*8 +: 8]);
  endtask

  // Scoreboard monitor: compares accepted words and checks hold stability while stalled.
  logic        held_v = 1'b0;
  logic [63:0] held_d;
  logic [63:0] held_b;
  always @(negedge clk) begin
    #2;
    if (m_valid && !rst) begin
      if (held_v) begin
        chk("hold_data", {32'h0, m_data}, held_d);
        chk("hold_bytes", {{(64-BW){1'b0}}, m_bytes}, held_b);
      end
      if (m_ready) begin
        if (sb_d.size() == 0) begin
          chk("unexpected_word", {32'h0, m_data}, 64'hX);
        end else begin
          chk("word_data", {32'h0, m_data}, sb_d.pop_front());
          chk("word_bytes", {{(64-BW){1'b0}}, m_bytes}, 64'(sb_b.pop_front()));
        end
        held_v = 1'b0;
      end else begin
        held_v = 1'b1;
        held_d = {32'h0, m_data};
        held_b = {{(64-BW){1'b0}}, m_bytes};
      end
    end else begin
      held_v = 1'b0;
    end
  end

  always @(negedge clk) if (z_valid) z_seen++;

  initial begin
    int pct;
    rst = 1'b1; flush_req = 1'b0; m_ready = 1'b1; z_empty = 1'b1; z_flush = 1'b0;
    fifo_empty = 1'b1; fifo_data = 8'h00; mdl_sending = 1'b0; idle = 0;
    @(negedge clk);
    run(2);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_data", m_data, 32'h0);
    chk("rst_m_bytes", m_bytes, 0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    // full word
    push4(32'h44332211); run(8);
    // stalled sink for 10 cycles
    push4(32'h8D7C6B5A); m_ready = 1'b0; run(14);
    m_ready = 1'b1; run(3);
    // idle timeout with two bytes
    fq.push_back(8'hAA); fq.push_back(8'hBB); run(24);
    // flush of a single byte, then flush with nothing held
    fq.push_back(8'h5A); run(3);
    flush_req = 1'b1; run(1); flush_req = 1'b0; run(4);
    flush_req = 1'b1; run(1); flush_req = 1'b0; run(3);
    // 16 bytes back to back
    for (int i = 0; i < 16; i++) fq.push_back(8'(i));
    run(30);
    chk("fifo_drained", fq.size(), 0);
    // reset after two of four bytes
    push4(32'hA4A3A2A1); run(2);
    rst = 1'b1; run(1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_m_valid", m_valid, 1'b0);
    fq.delete(); rst = 1'b0;
    push4(32'h04030201); run(8);
    // timeout disabled: partial word waits for a flush
    z_empty = 1'b0; run(2); z_empty = 1'b1; run(40);
    chk("notmo_no_valid", z_seen, 0);
    chk("notmo_busy", z_busy, 1'b1);
    z_flush = 1'b1; run(1); z_flush = 1'b0;
    chk("notmo_flush_valid", z_valid, 1'b1);
    chk("notmo_flush_data", z_data, 32'h0000AAAA);
    chk("notmo_flush_bytes", z_bytes, 2);
    run(2);
    // randomized traffic with varying fill rates
    pct = 50;
    for (int k = 0; k < 600; k++) begin
      if (k % 50 == 0) begin
        case ($urandom_range(0, 2))
          0:       pct = 0;
          1:       pct = 40;
          default: pct = 90;
        endcase
      end
      if (fq.size() < 16 && $urandom_range(0, 99) < pct) fq.push_back(8'($urandom));
      m_ready   = ($urandom_range(0, 3) != 0);
      flush_req = ($urandom_range(0, 19) == 0);
      cyc();
    end
    flush_req = 1'b0; m_ready = 1'b1;
    run(60);
    chk("final_sb_empty", sb_d.size(), 0);
    chk("final_fifo_empty", fq.size(), 0);
    chk("final_idle", busy, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
